// File: rtl/alarm_clock_ctrl.sv
// Alarm clock mode FSM, time-adjust strobes, BCD alarm registers and buzzer; all outputs registered, 1-cycle latency.
// No backpressure: each press/tick is acted on once or dropped. ALARM_TIMEOUT_EN adds an auto-stop ring counter.
module alarm_clock_ctrl #(
   parameter int RING_SECS = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       btn_c,
   input  logic       btn_l,
   input  logic       btn_r,
   input  logic       btn_u,
   input  logic       btn_d,
   input  logic [3:0] cur_min_u,
   input  logic [2:0] cur_min_t,
   input  logic [3:0] cur_hr_u,
   input  logic [1:0] cur_hr_t,
   input  logic       sec_zero,
   output logic       en,
   output logic       c_up_min,
   output logic       c_down_min,
   output logic       c_up_hour,
   output logic       c_down_hour,
   output logic [3:0] alm_min_u,
   output logic [2:0] alm_min_t,
   output logic [3:0] alm_hr_u,
   output logic [1:0] alm_hr_t,
   output logic [2:0] mode,
   output logic       alarm_armed,
   output logic       buzzer
);

   typedef enum logic [2:0] {
      CLOCK     = 3'd0,
      ADJ_T_HR  = 3'd1,
      ADJ_T_MIN = 3'd2,
      ADJ_A_HR  = 3'd3,
      ADJ_A_MIN = 3'd4
   } state_t;

   typedef enum logic [2:0] {P_NONE, P_C, P_R, P_L, P_U, P_D} press_t;

   state_t     state_q, state_d;
   press_t     press;
   logic       en_q, en_d;
   logic       up_min_q, up_min_d, down_min_q, down_min_d;
   logic       up_hour_q, up_hour_d, down_hour_q, down_hour_d;
   logic [3:0] alm_min_u_q, alm_min_u_d;
   logic [2:0] alm_min_t_q, alm_min_t_d;
   logic [3:0] alm_hr_u_q, alm_hr_u_d;
   logic [1:0] alm_hr_t_q, alm_hr_t_d;
   logic       armed_q, armed_d;
   logic       buzzer_q, buzzer_d;
   logic       match_q, match_d;
   logic       match;
   logic       ring_expire;

   function automatic logic [5:0] hr_step(input logic [1:0] t, input logic [3:0] u, input logic up);
      logic [5:0] r;
      if (up) begin
         if (t == 2'd2 && u == 4'd3) r = 6'd0;
         else if (u == 4'd9)         r = {t + 2'd1, 4'd0};
         else                        r = {t, u + 4'd1};
      end else begin
         if (t == 2'd0 && u == 4'd0) r = {2'd2, 4'd3};
         else if (u == 4'd0)         r = {t - 2'd1, 4'd9};
         else                        r = {t, u - 4'd1};
      end
      return r;
   endfunction

   function automatic logic [6:0] min_step(input logic [2:0] t, input logic [3:0] u, input logic up);
      logic [6:0] r;
      if (up) begin
         if (t == 3'd5 && u == 4'd9) r = 7'd0;
         else if (u == 4'd9)         r = {t + 3'd1, 4'd0};
         else                        r = {t, u + 4'd1};
      end else begin
         if (t == 3'd0 && u == 4'd0) r = {3'd5, 4'd9};
         else if (u == 4'd0)         r = {t - 3'd1, 4'd9};
         else                        r = {t, u - 4'd1};
      end
      return r;
   endfunction

   always_comb begin
      press = P_NONE;
      if (btn_c)      press = P_C;
      else if (btn_r) press = P_R;
      else if (btn_l) press = P_L;
      else if (btn_u) press = P_U;
      else if (btn_d) press = P_D;
   end

   assign match = (state_q == CLOCK) && armed_q && sec_zero &&
                  (cur_min_u == alm_min_u_q) && (cur_min_t == alm_min_t_q) &&
                  (cur_hr_u == alm_hr_u_q) && (cur_hr_t == alm_hr_t_q);

   always_comb begin
      state_d     = state_q;
      up_min_d    = 1'b0;
      down_min_d  = 1'b0;
      up_hour_d   = 1'b0;
      down_hour_d = 1'b0;
      alm_min_u_d = alm_min_u_q;
      alm_min_t_d = alm_min_t_q;
      alm_hr_u_d  = alm_hr_u_q;
      alm_hr_t_d  = alm_hr_t_q;
      armed_d     = armed_q;
      buzzer_d    = buzzer_q;
      match_d     = match;
      case (state_q)
         CLOCK: begin
            // While ringing, c and u only silence the buzzer.
            if (press == P_C) begin
               if (buzzer_q) buzzer_d = 1'b0;
               else          state_d  = ADJ_T_HR;
            end else if (press == P_U) begin
               if (buzzer_q) buzzer_d = 1'b0;
               else          armed_d  = ~armed_q;
            end
         end
         ADJ_T_HR, ADJ_T_MIN, ADJ_A_HR, ADJ_A_MIN: begin
            case (press)
               P_C: state_d = CLOCK;
               P_R: state_d = (state_q == ADJ_A_MIN) ? ADJ_T_HR : state_t'(state_q + 3'd1);
               P_L: state_d = (state_q == ADJ_T_HR) ? ADJ_A_MIN : state_t'(state_q - 3'd1);
               P_U, P_D: begin
                  case (state_q)
                     ADJ_T_HR:  begin up_hour_d = (press == P_U); down_hour_d = (press == P_D); end
                     ADJ_T_MIN: begin up_min_d  = (press == P_U); down_min_d  = (press == P_D); end
                     ADJ_A_HR:  {alm_hr_t_d, alm_hr_u_d}   = hr_step(alm_hr_t_q, alm_hr_u_q, press == P_U);
                     default:   {alm_min_t_d, alm_min_u_d} = min_step(alm_min_t_q, alm_min_u_q, press == P_U);
                  endcase
               end
               default: ;
            endcase
         end
         default: state_d = CLOCK;
      endcase
      // A tick coinciding with leaving CLOCK is dropped.
      en_d = tick_1hz && (state_q == CLOCK) && (state_d == CLOCK);
      if (ring_expire) buzzer_d = 1'b0;
      if (match && !match_q && (state_d == CLOCK)) buzzer_d = 1'b1;
      if (!armed_d) buzzer_d = 1'b0;
   end

`ifdef ALARM_TIMEOUT_EN
   logic [7:0] ring_cnt_q, ring_cnt_d;

   assign ring_expire = buzzer_q && tick_1hz && (ring_cnt_q == 8'(RING_SECS - 1));

   always_comb begin
      ring_cnt_d = ring_cnt_q;
      if (buzzer_q && tick_1hz) ring_cnt_d = ring_cnt_q + 8'd1;
      if (ring_expire || !buzzer_d) ring_cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) ring_cnt_q <= '0;
      else       ring_cnt_q <= ring_cnt_d;
   end
`else
   logic unused_ring_secs;
   assign ring_expire      = 1'b0;
   assign unused_ring_secs = ^RING_SECS;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= CLOCK;
         en_q        <= 1'b0;
         up_min_q    <= 1'b0;
         down_min_q  <= 1'b0;
         up_hour_q   <= 1'b0;
         down_hour_q <= 1'b0;
         alm_min_u_q <= '0;
         alm_min_t_q <= '0;
         alm_hr_u_q  <= '0;
         alm_hr_t_q  <= '0;
         armed_q     <= 1'b0;
         buzzer_q    <= 1'b0;
         match_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         en_q        <= en_d;
         up_min_q    <= up_min_d;
         down_min_q  <= down_min_d;
         up_hour_q   <= up_hour_d;
         down_hour_q <= down_hour_d;
         alm_min_u_q <= alm_min_u_d;
         alm_min_t_q <= alm_min_t_d;
         alm_hr_u_q  <= alm_hr_u_d;
         alm_hr_t_q  <= alm_hr_t_d;
         armed_q     <= armed_d;
         buzzer_q    <= buzzer_d;
         match_q     <= match_d;
      end
   end

   assign en          = en_q;
   assign c_up_min    = up_min_q;
   assign c_down_min  = down_min_q;
   assign c_up_hour   = up_hour_q;
   assign c_down_hour = down_hour_q;
   assign alm_min_u   = alm_min_u_q;
   assign alm_min_t   = alm_min_t_q;
   assign alm_hr_u    = alm_hr_u_q;
   assign alm_hr_t    = alm_hr_t_q;
   assign mode        = state_q;
   assign alarm_armed = armed_q;
   assign buzzer      = buzzer_q;

endmodule

// File: doc/alarm_clock_ctrl.md
# alarm_clock_ctrl

Mode controller for the digital alarm clock. It sequences the six-digit hours/minutes/seconds time counter: it gates the 1 Hz count enable and converts debounced button presses into the counter's minute and hour up/down strobes. It also owns the BCD alarm-time registers, the alarm arm state and the alarm compare, and drives the buzzer and the mode indicators. It sits between the button debouncers/1 Hz prescaler and the time counter.

## Interface
Parameters:
- RING_SECS, 60: ring duration in `tick_1hz` periods. Used only when `ALARM_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle pulse, once per second.
- `btn_c`, `btn_l`, `btn_r`, `btn_u`, `btn_d`  in  1 each  debounced single-cycle press pulses.
- `cur_min_u`  in  4  current minute units (BCD) from the time counter.
- `cur_min_t`  in  3  current minute tens.
- `cur_hr_u`  in  4  current hour units.
- `cur_hr_t`  in  2  current hour tens.
- `sec_zero`  in  1  high when the counter's seconds read 00.
- `en`  out  1  count enable to the time counter.
- `c_up_min`, `c_down_min`, `c_up_hour`, `c_down_hour`  out  1 each  single-cycle adjust strobes to the time counter.
- `alm_min_u` out 4, `alm_min_t` out 3, `alm_hr_u` out 4, `alm_hr_t` out 2  alarm time, BCD.
- `mode`  out  3  current FSM state, for the display and LEDs.
- `alarm_armed`  out  1  alarm is armed.
- `buzzer`  out  1  alarm is ringing.

## Operation
- FSM states: CLOCK=0, ADJ_T_HR=1, ADJ_T_MIN=2, ADJ_A_HR=3, ADJ_A_MIN=4.
- Button priority when several buttons are high in the same cycle: c > r > l > u > d. Only the highest-priority button is acted on; the others are dropped.
- CLOCK state:
  - `en` = `tick_1hz`.
  - `btn_c` → ADJ_T_HR.
  - `btn_u` toggles `alarm_armed`.
  - `btn_l`, `btn_r` and `btn_d` are ignored.
- Any ADJ_* state:
  - `en` = 0. The seconds are frozen; ticks are dropped, not queued.
  - `btn_r` steps to the next state: 1→2→3→4→1.
  - `btn_l` steps to the previous state: 1→4→3→2→1.
  - `btn_c` → CLOCK.
- ADJ_T_HR: `btn_u`/`btn_d` issue one `c_up_hour`/`c_down_hour` strobe. Wrap is handled by the counter.
- ADJ_T_MIN: `btn_u`/`btn_d` issue one `c_up_min`/`c_down_min` strobe.
- ADJ_A_HR: alarm hour inc/dec in BCD. 23→00 on inc, 00→23 on dec. Units 9→0 carries into tens.
- ADJ_A_MIN: alarm minute inc/dec in BCD. 59→00 on inc, 00→59 on dec. No carry into the alarm hour.
- Alarm compare:
  - `match` = CLOCK & `alarm_armed` & (cur hh:mm == alarm hh:mm) & `sec_zero`.
  - `buzzer` sets on the rising edge of `match`, using a registered copy of `match`. A dismissed alarm therefore does not re-trigger within the same second.
- While `buzzer` = 1:
  - `btn_c` clears `buzzer` and is consumed: no transition to ADJ_T_HR.
  - `btn_u` also clears `buzzer` and leaves `alarm_armed` unchanged.
- Disarming clears `buzzer` immediately.
- Leaving CLOCK is impossible while ringing, because `btn_c` is consumed.

## Timing
- All outputs are registered.
- Button-to-strobe latency: 1 cycle. Each strobe is exactly 1 cycle wide per press.
- `en`: 1-cycle pulse, asserted the cycle after `tick_1hz`.
- `buzzer` rises 1 cycle after `match` rises.
- Reset values:
  - `mode` = CLOCK.
  - Alarm = 00:00.
  - `alarm_armed` = 0, `buzzer` = 0, `en` = 0, all strobes = 0.
  - Internal registered `match` = 0 and ring counter = 0.
- Reset mid-adjust or mid-ring: the next cycle shows the reset values above; the press is lost.
- `tick_1hz` in the same cycle as `btn_c` leaving CLOCK: that tick is dropped. The mode change wins.

## Configuration
- `ALARM_TIMEOUT_EN` defined:
  - An 8-bit ring counter counts `tick_1hz` while `buzzer` = 1.
  - `buzzer` clears automatically on the RING_SECS-th tick. The counter then resets to 0.
- `ALARM_TIMEOUT_EN` undefined:
  - No counter is built.
  - `buzzer` holds until `btn_c`, `btn_u` or `reset`.

## Test plan
- Reset, then 3 `tick_1hz` pulses → `en` pulses 3 times, each 1 cycle after its tick. `mode`=0, `alarm_armed`=0.
- `btn_c`, `btn_u`, `btn_r`, `btn_d`, `btn_c` → `mode` 1,1,2,2,0. One `c_up_hour` pulse, then one `c_down_min` pulse. `en`=0 throughout adjust even when ticks arrive.
- ADJ_A_HR: 24× `btn_u` → alarm goes 00→23→00. Then `btn_d` → 23. In ADJ_A_MIN, `btn_d` from 00 → 59. `btn_l` from state 1 → 4.
- Alarm 07:30, armed. Present time 07:30 with `sec_zero`=1 → `buzzer`=1 next cycle. `btn_c` → `buzzer`=0, `mode` stays 0, no re-ring while `sec_zero` stays 1.
- Same cycle: `btn_c` and `btn_u` in CLOCK → only the transition to ADJ_T_HR happens; `alarm_armed` is unchanged.
- With `ALARM_TIMEOUT_EN`, RING_SECS=60: ring, then 60 ticks → `buzzer` clears after the 60th tick. Without the macro, `buzzer` is still 1 after 100 ticks.
